// File: rtl/mts_pkg.sv
// Shared types for the MTS SYSREF gate controller: FSM states and error codes.
package mts_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EDGE,
    MEASURE,
    ARM,
    PASS,
    DONE,
    ERR
  } mts_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_LOSTLOCK = 2'd2;

endpackage

// File: rtl/sysref_period_meter.sv
// SYSREF edge detector and free-running period meter; flags whether the period
// ending at the current rise is within tolerance of the expected one.
module sysref_period_meter #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          sysref_in,
  input  logic [PW-1:0] period_exp,
  input  logic [3:0]    period_tol,
  output logic          sysref_q,
  output logic          rise,
  output logic          fall,
  output logic          match,
  output logic [PW-1:0] period_meas
);

  logic [PW-1:0] pcnt;
  logic [PW:0]   cur;
  logic [PW:0]   exp_w;
  logic [PW:0]   diff;

  assign rise  = sysref_in & ~sysref_q;
  assign fall  = ~sysref_in & sysref_q;

  // One extra bit so pcnt+1 never wraps and the distance is exact.
  assign cur   = {1'b0, pcnt} + {{PW{1'b0}}, 1'b1};
  assign exp_w = {1'b0, period_exp};
  assign diff  = (cur >= exp_w) ? (cur - exp_w) : (exp_w - cur);
  assign match = (diff <= {{(PW-3){1'b0}}, period_tol});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sysref_q    <= 1'b0;
      pcnt        <= '0;
      period_meas <= '0;
    end else begin
      sysref_q <= sysref_in;
      if (rise) begin
        pcnt        <= '0;
        period_meas <= cur[PW] ? '1 : cur[PW-1:0];
      end else if (pcnt != '1) begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mts_sysref_gate_ctrl.sv
// SYSREF delivery sequencer for RFSoC MTS: acquire lock on the SYSREF period,
// then forward exactly n_pass whole pulses and close the gate.
module mts_sysref_gate_ctrl
  import mts_pkg::*;
#(
  parameter int PW = 16,
  parameter int CW = 8,
  parameter int TW = 24
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          sysref_in,
  input  logic          start,
  input  logic          abort,
  input  logic [PW-1:0] period_exp,
  input  logic [3:0]    period_tol,
  input  logic [CW-1:0] n_stable,
  input  logic [CW-1:0] n_pass,
  input  logic [TW-1:0] timeout,
  output logic          sysref_out,
  output logic          busy,
  output logic          locked,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [PW-1:0] period_meas,
  output logic [CW-1:0] pass_cnt
);

  mts_state_e    state;
  logic          sysref_q, rise, fall, match;
  logic          gate, to_hit, kill;
  logic [TW-1:0] timer, timer_nx;
  logic [CW-1:0] stable, stable_nx, ns_eff, pass_nx;

  sysref_period_meter #(.PW(PW)) u_meter (
    .clk        (clk),
    .rstn       (rstn),
    .sysref_in  (sysref_in),
    .period_exp (period_exp),
    .period_tol (period_tol),
    .sysref_q   (sysref_q),
    .rise       (rise),
    .fall       (fall),
    .match      (match),
    .period_meas(period_meas)
  );

  assign ns_eff    = (n_stable == '0) ? {{(CW-1){1'b0}}, 1'b1} : n_stable;
  assign stable_nx = stable + 1'b1;
  assign pass_nx   = pass_cnt + 1'b1;
  assign timer_nx  = timer + 1'b1;
  assign to_hit    = (timeout != '0) && (timer_nx >= timeout);
  assign busy      = !(state inside {IDLE, DONE, ERR});

  // A mis-timed rise in PASS must not leak even one cycle of the bad pulse.
  assign kill = abort || ((state == PASS) && rise && !match);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sysref_out <= 1'b0;
    else       sysref_out <= gate & sysref_in & ~kill;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      gate     <= 1'b0;
      locked   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      pass_cnt <= '0;
      timer    <= '0;
      stable   <= '0;
    end else if (abort) begin
      state    <= IDLE;
      gate     <= 1'b0;
      locked   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= WAIT_EDGE;
            gate     <= 1'b0;
            locked   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            pass_cnt <= '0;
            timer    <= '0;
            stable   <= '0;
          end
        end
        WAIT_EDGE, MEASURE: begin
          timer <= timer_nx;
          if (to_hit) begin
            state    <= ERR;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end else if (rise && state == WAIT_EDGE) begin
            state  <= MEASURE;
            stable <= '0;
          end else if (rise) begin
            if (!match) begin
              stable <= '0;
            end else begin
              stable <= stable_nx;
              if (stable_nx >= ns_eff) begin
                locked <= 1'b1;
                state  <= ARM;
              end
            end
          end
        end
        ARM: begin
          if (n_pass == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (!sysref_in && !sysref_q) begin
            gate  <= 1'b1;
            state <= PASS;
          end
        end
        PASS: begin
          if (rise && !match) begin
            gate     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_LOSTLOCK;
            locked   <= 1'b0;
            state    <= ERR;
          end else if (fall) begin
            pass_cnt <= pass_nx;
            if (pass_nx == n_pass) begin
              gate  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mts_sysref_gate_ctrl.md
Name: mts_sysref_gate_ctrl

Overview:
- Sequences SYSREF delivery for RFSoC multi-tile sync (MTS).
- Input is the clk104 PL SYSREF, already registered in the PL clock domain.
- On software start, the block measures the SYSREF period, declares lock after N consecutive in-tolerance periods, then passes exactly n_pass whole SYSREF pulses to the RFDC/MTS logic and closes the gate.
- Reports lock, done, error and the measured period to software registers.

Parameters:
- PW, 16, width of period counter / period config.
- CW, 8, width of stable and pass counters.
- TW, 24, width of acquisition timeout counter.

Ports:
- clk  in  1  PL clock (clk104 PL clock after BUFG).
- rstn  in  1  asynchronous active-low reset.
- sysref_in  in  1  SYSREF, synchronous to clk.
- start  in  1  single-cycle start pulse.
- abort  in  1  single-cycle abort pulse.
- period_exp  in  PW  expected SYSREF period, in clk cycles.
- period_tol  in  4  allowed |measured - expected|.
- n_stable  in  CW  consecutive matching periods required for lock; 0 is treated as 1.
- n_pass  in  CW  SYSREF pulses to forward.
- timeout  in  TW  acquisition timeout in cycles; 0 disables.
- sysref_out  out  1  gated SYSREF to MTS.
- busy  out  1  FSM not in IDLE/DONE/ERR.
- locked  out  1  lock achieved in the current run.
- done  out  1  pass sequence completed.
- err  out  1  error flag.
- err_code  out  2  0 none, 1 timeout, 2 lost lock during PASS, 3 reserved.
- period_meas  out  PW  last measured period.
- pass_cnt  out  CW  pulses forwarded so far.

Behaviour:
- Reset (async, rstn=0): all outputs 0; FSM in IDLE; all counters 0.
- Edge detection:
  - sysref_q <= sysref_in.
  - rise = sysref_in & ~sysref_q; fall = ~sysref_in & sysref_q.
- Period meter:
  - pcnt clears to 0 on rise; otherwise increments, saturating at all-ones.
  - On rise, period_meas <= pcnt+1, saturating. Example: rises 8 cycles apart give 8.
  - match = |pcnt+1 - period_exp| <= period_tol; use a PW+1-bit difference.
- sysref_out <= gate & sysref_in (registered).
  - Latency is one cycle from sysref_in.
  - gate only opens while sysref_in=0 and sysref_q=0, so no partial pulses are emitted.
- FSM:
  - IDLE: on start, clear locked/done/err/pass_cnt/timer and go to WAIT_EDGE.
  - WAIT_EDGE: timer++. On first rise, go to MEASURE with stable=0. The first period is not evaluated.
  - MEASURE: timer++.
    - On rise with match: stable++. When stable+1 >= max(n_stable,1), set locked=1 and go to ARM.
    - On rise with no match: stable=0.
  - ARM:
    - If n_pass==0, go to DONE with the gate never opened.
    - Otherwise, when sysref_in=0 and sysref_q=0, set gate=1 and go to PASS.
  - PASS:
    - On fall: pass_cnt++. If pass_cnt+1==n_pass, set gate=0 and go to DONE.
    - On rise with no match: gate=0, err=1, err_code=2, locked=0, go to ERR.
  - DONE: done=1, gate=0. start begins a new run, same as from IDLE.
  - ERR: err held. start begins a new run and clears err/err_code.
- Timeout: if timeout!=0 and timer reaches timeout in WAIT_EDGE or MEASURE, go to ERR with err_code=1.
- Abort:
  - abort in any state goes to IDLE next cycle, sets gate=0 and clears locked/done/err/err_code.
  - pass_cnt and period_meas retain their values.
- Priority: abort > start. start while busy is ignored.
- Config inputs are sampled continuously; software holds them stable while busy. Behaviour on change mid-run is not guaranteed.
- Reset mid-PASS: gate closes asynchronously and sysref_out goes to 0 immediately.

Decomposition:
- Package mts_pkg holds:
  - FSM state enum: IDLE, WAIT_EDGE, MEASURE, ARM, PASS, DONE, ERR.
  - err_code constants: ERR_NONE, ERR_TIMEOUT, ERR_LOSTLOCK.
- Sub-module sysref_period_meter holds edge detection, pcnt and period_meas, and outputs rise/fall/match.

Test Plan:
- Period 8, tol 0, n_stable 4, n_pass 2, timeout 0 -> locked on the 5th rise; exactly 2 full-width pulses on sysref_out, each 1 cycle after sysref_in; done=1; pass_cnt=2; period_meas=8.
- Periods alternate 8/9, tol 0, timeout 200 -> never locked; err=1, err_code=1 at cycle 200 after start; sysref_out stays 0. Repeat with tol 1 -> locks.
- Locked and in PASS with n_pass=5, inject one period of 12 -> gate closes at that rise with no pulse forwarded; err_code=2; locked=0.
- start issued while sysref_in=1 with n_pass=1 -> the in-flight pulse is not forwarded; the next pulse is forwarded whole.
- abort during PASS after 1 pulse, with start asserted in the same cycle -> IDLE; sysref_out=0; pass_cnt=1 retained; start ignored. n_pass=0 run -> done with zero pulses.
- rstn deasserted mid-PASS -> all outputs 0 immediately; after release, a new start runs a clean sequence.
